// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: DEPTH-entry FIFO of {pc, instr, pc_plus4}
// with valid/ready handshakes on both sides and a flush that empties it in one cycle.
module fetch_queue #(
   parameter int unsigned          DEPTH    = 4,
   parameter int unsigned          XLEN     = 32,
   parameter logic [XLEN-1:0]      NOP_INSN = 32'h0000_0013
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     if_valid,
   input  logic [XLEN-1:0]          if_pc,
   input  logic [XLEN-1:0]          if_pc_plus4,
   input  logic [XLEN-1:0]          if_instr,
   output logic                     if_ready,
   output logic                     id_valid,
   input  logic                     id_ready,
   output logic [XLEN-1:0]          id_pc,
   output logic [XLEN-1:0]          id_pc_plus4,
   output logic [XLEN-1:0]          id_instr,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [XLEN-1:0] r_pc    [DEPTH];
   logic [XLEN-1:0] r_pc_p4 [DEPTH];
   logic [XLEN-1:0] r_instr [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_push  = if_valid & ~w_full & ~flush;
   assign w_pop   = ~w_empty & id_ready & ~flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
   end

   // Storage needs no reset: occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc[r_wr_ptr]    <= if_pc;
         r_pc_p4[r_wr_ptr] <= if_pc_plus4;
         r_instr[r_wr_ptr] <= if_instr;
      end
   end

   always_comb begin
      id_pc       = '0;
      id_pc_plus4 = '0;
      id_instr    = NOP_INSN;
      if (!w_empty) begin
         id_pc       = r_pc[r_rd_ptr];
         id_pc_plus4 = r_pc_p4[r_rd_ptr];
         id_instr    = r_instr[r_rd_ptr];
      end
   end

   assign if_ready = ~w_full;
   assign id_valid = ~w_empty;
   assign count    = r_count;

   a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(w_push && w_full));
   a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(w_pop && w_empty));
   a_count_range:  assert property (@(posedge clk) disable iff (!rst_n) r_count <= CW'(DEPTH));

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic checked against a queue model.
module tb_fetch_queue;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned XLEN  = 32;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pp4;
      logic [31:0] instr;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic [31:0] if_instr;
   logic        if_ready;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
   logic [31:0] id_instr;
   logic [2:0]  count;

   ent_t q[$];
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .NOP_INSN(NOP)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .if_valid(if_valid), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .if_instr(if_instr),
      .if_ready(if_ready), .id_valid(id_valid), .id_ready(id_ready),
      .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_instr(id_instr), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic check_all(input string tag);
      ent_t h;
      h = (q.size() == 0) ? '{pc: '0, pp4: '0, instr: NOP} : q[0];
      chk({tag, ".count"},    64'(count),       64'(q.size()));
      chk({tag, ".id_valid"}, 64'(id_valid),    64'(q.size() != 0));
      chk({tag, ".if_ready"}, 64'(if_ready),    64'(q.size() < DEPTH));
      chk({tag, ".id_pc"},    64'(id_pc),       64'(h.pc));
      chk({tag, ".id_pp4"},   64'(id_pc_plus4), 64'(h.pp4));
      chk({tag, ".id_instr"}, 64'(id_instr),    64'(h.instr));
   endtask

   // Drive one cycle of stimulus, advance the model across the edge, then compare.
   task automatic step(input string tag, input logic v, input logic r, input logic f,
                       input logic [31:0] pc, input logic [31:0] ins);
      logic do_push, do_pop;
      if_valid    = v;
      id_ready    = r;
      flush       = f;
      if_pc       = pc;
      if_pc_plus4 = pc + 32'd4;
      if_instr    = ins;
      do_push = v && (q.size() < DEPTH) && !f;
      do_pop  = (q.size() > 0) && r && !f;
      @(posedge clk);
      if (f) q.delete();
      else begin
         if (do_pop)  void'(q.pop_front());
         if (do_push) q.push_back('{pc: pc, pp4: pc + 32'd4, instr: ins});
      end
      #1;
      check_all(tag);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
      if_pc = '0; if_pc_plus4 = '0; if_instr = '0;
      #3;
      check_all("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // mid-stream asynchronous reset with three entries buffered
      for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 1'b0, 1'b0, 32'(i * 4), 32'hA000 + 32'(i));
      chk("pre_rst.count3", 64'(count), 64'd3);
      #3 rst_n = 1'b0;
      #1;
      q.delete();
      chk("async_rst.count",    64'(count),    64'd0);
      chk("async_rst.id_valid", 64'(id_valid), 64'd0);
      chk("async_rst.id_instr", 64'(id_instr), 64'h13);
      chk("async_rst.if_ready", 64'(if_ready), 64'd1);
      #2 rst_n = 1'b1;

      // fill: fifth entry refused, head stays at pc 0
      for (int i = 0; i < 5; i++) step("fill", 1'b1, 1'b0, 1'b0, 32'(i * 4), 32'hB000 + 32'(i));
      chk("fill.full_ready", 64'(if_ready), 64'd0);
      chk("fill.head_pc",    64'(id_pc),    64'd0);

      // drain in order
      for (int i = 0; i < 4; i++) begin
         chk("drain.seq_pc", 64'(id_pc), 64'(i * 4));
         step("drain", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      end
      chk("drain.empty", 64'(id_valid), 64'd0);

      // streaming from empty: one cycle latency, then occupancy stays at 1
      for (int i = 0; i < 8; i++) begin
         step("stream", 1'b1, 1'b1, 1'b0, 32'h100 + 32'(i * 4), 32'hC000 + 32'(i));
         chk("stream.count1", 64'(count), 64'd1);
         chk("stream.head",   64'(id_pc), 64'(32'h100 + 32'(i * 4)));
      end
      step("stream_end", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

      // full + pop: push refused this cycle, accepted next
      for (int i = 0; i < 4; i++) step("fill2", 1'b1, 1'b0, 1'b0, 32'h300 + 32'(i * 4), 32'hD000 + 32'(i));
      step("fullpop", 1'b1, 1'b1, 1'b0, 32'h310, 32'hD004);
      chk("fullpop.count3", 64'(count), 64'd3);
      step("fullpop2", 1'b1, 1'b1, 1'b0, 32'h310, 32'hD004);
      chk("fullpop2.count3", 64'(count), 64'd3);

      // flush drops everything including the entry offered that cycle
      step("flush", 1'b1, 1'b1, 1'b1, 32'h999, 32'hDEAD);
      chk("flush.count0", 64'(count), 64'd0);
      step("redirect", 1'b1, 1'b0, 1'b0, 32'h200, 32'hE000);
      chk("redirect.head", 64'(id_pc), 64'h200);
      step("redirect_drain", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

      // random traffic
      for (int i = 0; i < 400; i++)
         step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 24) == 0), $urandom, $urandom);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, got running expected done");
      $fatal(1);
   end

endmodule
